// File: rtl/vector_unit_pkg.sv
// rtl/vector_unit_pkg.sv - shared vector multiply types, operation encoding and lane saturation helpers
package vector_unit_pkg;

    typedef enum logic [1:0] {
        BIT8  = 2'b00,
        BIT16 = 2'b01
    } esize_t;

    localparam logic OP_ACCUMULATE = 1'b0;
    localparam logic OP_SATURATE   = 1'b1;

    // One 64-bit product viewed as two 32-bit (BIT16) or four 16-bit (BIT8) lane products
    typedef union packed {
        logic [1:0][31:0] vect2;
        logic [3:0][15:0] vect4;
        logic [63:0]      raw;
    } vmul_vector_t;

    function automatic logic [31:0] byte_sum(input logic [31:0] w);
        return 32'(w[7:0]) + 32'(w[15:8]) + 32'(w[23:16]) + 32'(w[31:24]);
    endfunction

    // {overflow, value}: Q15 rescale of a 16x16 product, clamped to int16
    function automatic logic [16:0] sat16(input logic [31:0] lane);
        logic signed [31:0] s;
        s = $signed(lane) >>> 15;
        if (s > 32'sd32767)
            return {1'b1, 16'h7FFF};
        else if (s < -32'sd32768)
            return {1'b1, 16'h8000};
        else
            return {1'b0, s[15:0]};
    endfunction

    // {overflow, value}: Q7 rescale of an 8x8 product, clamped to int8
    function automatic logic [8:0] sat8(input logic [15:0] lane);
        logic signed [15:0] s;
        s = $signed(lane) >>> 7;
        if (s > 16'sd127)
            return {1'b1, 8'h7F};
        else if (s < -16'sd128)
            return {1'b1, 8'h80};
        else
            return {1'b0, s[7:0]};
    endfunction

endpackage

// File: rtl/vector_accumulator.sv
// rtl/vector_accumulator.sv - combinational accumulate / per-lane saturate datapath
module vector_accumulator
    import vector_unit_pkg::*;
(
    input  vmul_vector_t product,
    input  logic [31:0]  seed,
    input  logic         operation,
    input  esize_t       element_size,
    output logic [31:0]  result,
    output logic         overflow
);

    logic [16:0] lane16;
    logic [8:0]  lane8;

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        lane16   = '0;
        lane8    = '0;
        case (operation)
            OP_ACCUMULATE: begin
                result = seed + byte_sum(product.raw[31:0]);
            end
            OP_SATURATE: begin
                if (element_size == BIT8) begin
                    for (int i = 0; i < 4; i++) begin
                        lane8             = sat8(product.vect4[i]);
                        result[8*i +: 8]  = lane8[7:0];
                        overflow          = overflow | lane8[8];
                    end
                end else begin
                    for (int i = 0; i < 2; i++) begin
                        lane16            = sat16(product.vect2[i]);
                        result[16*i +: 16] = lane16[15:0];
                        overflow          = overflow | lane16[16];
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/vmul_sequencer.sv
// rtl/vmul_sequencer.sv - issue/multiply/accumulate/result sequencer around an external vector multiplier
module vmul_sequencer
    import vector_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         issue_valid_i,
    output logic         issue_ready_o,
    input  logic [31:0]  operand_a_i,
    input  logic [31:0]  operand_b_i,
    input  logic [31:0]  reg_destination_i,
    input  logic         operation_i,
    input  esize_t       element_size_i,
    output logic         mul_valid_o,
    output logic [31:0]  mul_operand_a_o,
    output logic [31:0]  mul_operand_b_o,
    output esize_t       mul_element_size_o,
    input  logic         mul_done_i,
    input  vmul_vector_t mul_result_i,
    input  logic         kill_i,
    output logic         result_valid_o,
    input  logic         result_ready_i,
    output logic [31:0]  result_o,
    output logic         overflow_o,
    output logic         error_o,
    output logic         busy_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        ACC,
        RESULT
    } state_t;

    state_t       state_q;
    logic [CW-1:0] count_q;
    logic [31:0]  a_q;
    logic [31:0]  b_q;
    logic [31:0]  seed_q;
    logic         op_q;
    esize_t       esize_q;
    vmul_vector_t prod_q;
    logic [31:0]  acc_result;
    logic         acc_overflow;
    logic         issue_fire;

    assign issue_ready_o = !kill_i &&
                           (state_q == IDLE || (state_q == RESULT && result_ready_i));
    assign issue_fire    = issue_valid_i && issue_ready_o;

    assign mul_operand_a_o    = a_q;
    assign mul_operand_b_o    = b_q;
    assign mul_element_size_o = esize_q;

    vector_accumulator u_acc (
        .product      (prod_q),
        .seed         (seed_q),
        .operation    (op_q),
        .element_size (esize_q),
        .result       (acc_result),
        .overflow     (acc_overflow)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q        <= IDLE;
            count_q        <= '0;
            a_q            <= '0;
            b_q            <= '0;
            seed_q         <= '0;
            op_q           <= OP_ACCUMULATE;
            esize_q        <= BIT8;
            prod_q         <= '0;
            mul_valid_o    <= 1'b0;
            result_valid_o <= 1'b0;
            result_o       <= '0;
            overflow_o     <= 1'b0;
            error_o        <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            mul_valid_o <= 1'b0;
            if (kill_i) begin
                state_q        <= IDLE;
                busy_o         <= 1'b0;
                result_valid_o <= 1'b0;
                error_o        <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: ;
                    MUL_WAIT: begin
                        if (mul_done_i) begin
                            prod_q  <= mul_result_i;
                            state_q <= ACC;
                        end else if (count_q == CW'(TIMEOUT_CYCLES - 1)) begin
                            state_q        <= RESULT;
                            result_valid_o <= 1'b1;
                            result_o       <= '0;
                            overflow_o     <= 1'b0;
                            error_o        <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                    ACC: begin
                        result_o       <= acc_result;
                        overflow_o     <= acc_overflow;
                        error_o        <= 1'b0;
                        result_valid_o <= 1'b1;
                        state_q        <= RESULT;
                    end
                    RESULT: begin
                        if (result_ready_i) begin
                            result_valid_o <= 1'b0;
                            error_o        <= 1'b0;
                            state_q        <= IDLE;
                            busy_o         <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
                // A new issue overrides the IDLE return, giving back-to-back ops from RESULT
                if (issue_fire) begin
                    a_q         <= operand_a_i;
                    b_q         <= operand_b_i;
                    seed_q      <= reg_destination_i;
                    op_q        <= operation_i;
                    esize_q     <= (element_size_i == BIT8) ? BIT8 : BIT16;
                    count_q     <= '0;
                    mul_valid_o <= 1'b1;
                    busy_o      <= 1'b1;
                    state_q     <= MUL_WAIT;
                end
            end
        end
    end

endmodule
